fsm_control_gen2: RTL and testbench
===================================

# fsm_control_gen2

Parametrised successor to the multicycle CPU control FSM. Sequences fetch/decode/execute for the 16-instruction ISA and drives the same datapath select/enable encodings. Adds a memory request/ready handshake with an optional timeout, signed branch conditions from a wider status word, a resumable halt, and a trap state for illegal opcodes and memory timeouts. Sits between the instruction register/status register and the datapath muxes, ALU, register file and memory.

## Interface
- OPCODE_W, 4: opcode width, ≥4; opcode values ≥16 are illegal.
- STATUS_W, 2: status width, 2 ({N,Z}) or 4 ({V,C,N,Z}); bit 0=Z, 1=N, 2=C, 3=V.
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, accesses take one cycle.
- MEM_TIMEOUT, 0: 0 = no timeout; N>0 = trap after N wait cycles without mem_ready.
- clk in 1: clock, rising edge.
- reset in 1: asynchronous, active-low reset.
- opcode in OPCODE_W: current instruction opcode.
- status in STATUS_W: registered ALU status.
- mem_ready in 1: memory completed the current request.
- resume in 1: leave HALT.
- status_we out 1; alu_op out 3; alu_in0 out 1; alu_in1 out 2: ALU controls. Encodings: op AND0 OR1 XOR2 ADD3 SUB4; in0 OUT0=0 PC=1; in1 OUT1=0 INS=1 ONE=2.
- memory_write out 1; memory_addr out 2 (PC0 OUT0=1 OUT1=2); ins_reg out 1: memory controls.
- mem_req out 1: memory request.
- reg_data out 2 (IMM0 MEM1 ALU2 OUT1=3); reg_addr out 2 (D0 S1=1 PC2); regfile_write out 1: register-file controls.
- halted out 1; trap out 1; trap_cause out 2 (01 illegal opcode, 10 memory timeout).
- state out 4: debug copy of the current state.

## Operation
- Moore FSM. Outputs decode the registered state, except ins_reg and memory-state exits, which also qualify on mem_ready. "ready" below means mem_ready when MEM_HANDSHAKE=1, else constant 1.
- Default outputs (any state not overriding them): alu_in0=PC, alu_in1=ONE, alu_op=ADD, memory_addr=PC, reg_data=IMM, reg_addr=D; every enable, mem_req, halted and trap = 0.
- States (encoding 0..D): FETCH_0, FETCH_1, DECODE, HALT, REG_0, REG_1, LD_0, LD_1, STR_0, MOV_0, MVR_0, BR_0, BR_1, TRAP.
- FETCH_0: mem_req=1; ins_reg = ready. On ready → FETCH_1.
- FETCH_1: regfile_write=1, reg_data=ALU, reg_addr=PC (writes PC+1). → DECODE.
- DECODE: no enables asserted. Next state by opcode:
  - 1–5 or A → REG_0; 0 → HALT; 6 → LD_0; 7 → STR_0; 8 → MOV_0; 9 → MVR_0; B → BR_0.
  - C (BEQ): Z ? BR_0 : FETCH_0.
  - D (BNE): !Z ? BR_0 : FETCH_0.
  - E (BLT): (N^V) ? BR_0 : FETCH_0.
  - F (BGT): (!Z & !(N^V)) ? BR_0 : FETCH_0.
  - opcode ≥16 → TRAP, trap_cause=01.
  - When STATUS_W=2, V reads as 0.
- REG_0: alu_in0=OUT0, alu_in1=OUT1, status_we=1. alu_op: AND→0, OR→1, XOR→2, ADD→3, SUB/CMP→4. CMP → FETCH_0; others → REG_1.
- REG_1: alu selects and alu_op held from REG_0; regfile_write=1, reg_data=ALU, reg_addr=D. → FETCH_0.
- LD_0: mem_req=1, memory_addr=OUT1. On ready → LD_1.
- LD_1: memory_addr=OUT1, reg_data=MEM, reg_addr=S1, regfile_write=1. → FETCH_0.
- STR_0: mem_req=1, memory_addr=OUT0, memory_write=1 for the whole wait. On ready → FETCH_0.
- MOV_0: regfile_write=1, reg_data=IMM, reg_addr=D. MVR_0: regfile_write=1, reg_data=OUT1, reg_addr=S1. Both → FETCH_0.
- BR_0: alu_in1=INS (PC+offset). BR_1: same ALU selects, regfile_write=1, reg_data=ALU, reg_addr=PC. → FETCH_0.
- HALT: halted=1. resume=1 → FETCH_0.
- TRAP: trap=1, trap_cause held. Left only by reset.
- Timeout counter (MEM_TIMEOUT>0): clears on entry to any memory state and on ready. It increments each memory-state cycle without ready. If the count reaches MEM_TIMEOUT without ready → TRAP, trap_cause=10.

## Timing
- Reset asserted: state=FETCH_0; trap_cause=00; counter=0. Outputs are the FETCH_0 decode: mem_req=1, ins_reg=0, all write enables 0, alu PC+1, memory_addr=PC.
- First fetch completes on the first clk edge after reset deasserts with mem_ready=1.
- Reset mid-operation (including mid-STR_0 or in TRAP) aborts immediately; memory_write drops asynchronously.
- Zero-wait cycle counts: REG 5, CMP 4, LD 5, STR 4, MOV/MVR 4, taken branch 5, untaken branch 3. Each memory wait cycle adds 1.
- resume sampled only in HALT. mem_ready is ignored outside memory states.
- If timeout and ready occur in the same cycle, ready wins.

## Test plan
- ADD opcode=4, mem_ready=1 → states 0,1,2,4,5,0. status_we=1 only in REG_0; regfile_write=1 in FETCH_1 and REG_1, with reg_addr=PC then D.
- LD with mem_ready low 3 cycles in LD_0 → mem_req held 4 cycles, memory_addr=OUT1, then LD_1 writes reg_data=MEM to S1.
- BLT with STATUS_W=4, status=4'b1000 (V=1, N=0) → branch taken (BR_0, BR_1). With status=4'b1010 → FETCH_0 after DECODE.
- MEM_TIMEOUT=4, mem_ready=0 in STR_0 → TRAP after 4 wait cycles, trap_cause=10, memory_write falls. Reset → FETCH_0.
- OPCODE_W=5, opcode=5'h13 → TRAP, trap_cause=01. Opcode 0 → HALT with halted=1; resume pulse → FETCH_0 next cycle.
- Reset low asynchronously mid-BR_0 → state=0 before the next edge; all enables 0.

Source files
------------

// File: rtl/fsm_control_gen2.sv
// Multicycle CPU control FSM: fetch/decode/execute sequencing with a memory
// request/ready handshake, optional memory timeout, resumable halt and trap.
module fsm_control_gen2 #(
  parameter int OPCODE_W      = 4,
  parameter int STATUS_W      = 2,
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_TIMEOUT   = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [STATUS_W-1:0] status_i,
  input  logic                mem_ready_i,
  input  logic                resume_i,
  output logic                status_we_o,
  output logic [2:0]          alu_op_o,
  output logic                alu_in0_o,
  output logic [1:0]          alu_in1_o,
  output logic                memory_write_o,
  output logic [1:0]          memory_addr_o,
  output logic                ins_reg_o,
  output logic                mem_req_o,
  output logic [1:0]          reg_data_o,
  output logic [1:0]          reg_addr_o,
  output logic                regfile_write_o,
  output logic                halted_o,
  output logic                trap_o,
  output logic [1:0]          trap_cause_o,
  output logic [3:0]          state_o
);

  typedef enum logic [3:0] {
    FETCH_0 = 4'h0,
    FETCH_1 = 4'h1,
    DECODE  = 4'h2,
    HALT    = 4'h3,
    REG_0   = 4'h4,
    REG_1   = 4'h5,
    LD_0    = 4'h6,
    LD_1    = 4'h7,
    STR_0   = 4'h8,
    MOV_0   = 4'h9,
    MVR_0   = 4'hA,
    BR_0    = 4'hB,
    BR_1    = 4'hC,
    TRAP    = 4'hD
  } state_e;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_ADD  = 3'd3;
  localparam logic [2:0] ALU_SUB  = 3'd4;

  localparam logic       IN0_OUT0 = 1'b0;
  localparam logic       IN0_PC   = 1'b1;
  localparam logic [1:0] IN1_OUT1 = 2'd0;
  localparam logic [1:0] IN1_INS  = 2'd1;
  localparam logic [1:0] IN1_ONE  = 2'd2;

  localparam logic [1:0] ADDR_PC   = 2'd0;
  localparam logic [1:0] ADDR_OUT0 = 2'd1;
  localparam logic [1:0] ADDR_OUT1 = 2'd2;

  localparam logic [1:0] DATA_IMM  = 2'd0;
  localparam logic [1:0] DATA_MEM  = 2'd1;
  localparam logic [1:0] DATA_ALU  = 2'd2;
  localparam logic [1:0] DATA_OUT1 = 2'd3;

  localparam logic [1:0] RA_D  = 2'd0;
  localparam logic [1:0] RA_S1 = 2'd1;
  localparam logic [1:0] RA_PC = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef struct packed {
    logic       statusWe;
    logic [2:0] aluOp;
    logic       aluIn0;
    logic [1:0] aluIn1;
    logic       memWrite;
    logic [1:0] memAddr;
    logic       memReq;
    logic [1:0] regData;
    logic [1:0] regAddr;
    logic       regWrite;
    logic       halted;
    logic       trap;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  ctrl_t            ctrl_q;

  logic       ready;
  logic       memState;
  logic       timeout;
  logic       illegalOp;
  logic [3:0] lowOp;
  logic       flagZ, flagN, flagV;
  logic       unusedInputs;

  function automatic logic [2:0] regAluOp(input logic [3:0] op);
    logic [2:0] aluOp;
    case (op)
      4'h1:    aluOp = ALU_AND;
      4'h2:    aluOp = ALU_OR;
      4'h3:    aluOp = ALU_XOR;
      4'h4:    aluOp = ALU_ADD;
      default: aluOp = ALU_SUB;
    endcase
    return aluOp;
  endfunction

  // Control word for a given state; registered so outputs come straight off flops.
  function automatic ctrl_t decodeCtrl(input state_e s, input logic [3:0] op);
    ctrl_t c;
    c         = '0;
    c.aluOp   = ALU_ADD;
    c.aluIn0  = IN0_PC;
    c.aluIn1  = IN1_ONE;
    c.memAddr = ADDR_PC;
    c.regData = DATA_IMM;
    c.regAddr = RA_D;
    case (s)
      FETCH_0: c.memReq = 1'b1;
      FETCH_1: begin
        c.regWrite = 1'b1;
        c.regData  = DATA_ALU;
        c.regAddr  = RA_PC;
      end
      REG_0, REG_1: begin
        c.aluIn0 = IN0_OUT0;
        c.aluIn1 = IN1_OUT1;
        c.aluOp  = regAluOp(op);
        if (s == REG_0) begin
          c.statusWe = 1'b1;
        end else begin
          c.regWrite = 1'b1;
          c.regData  = DATA_ALU;
          c.regAddr  = RA_D;
        end
      end
      LD_0: begin
        c.memReq  = 1'b1;
        c.memAddr = ADDR_OUT1;
      end
      LD_1: begin
        c.memAddr  = ADDR_OUT1;
        c.regData  = DATA_MEM;
        c.regAddr  = RA_S1;
        c.regWrite = 1'b1;
      end
      STR_0: begin
        c.memReq   = 1'b1;
        c.memWrite = 1'b1;
        c.memAddr  = ADDR_OUT0;
      end
      MOV_0: c.regWrite = 1'b1;
      MVR_0: begin
        c.regWrite = 1'b1;
        c.regData  = DATA_OUT1;
        c.regAddr  = RA_S1;
      end
      BR_0: c.aluIn1 = IN1_INS;
      BR_1: begin
        c.aluIn1   = IN1_INS;
        c.regWrite = 1'b1;
        c.regData  = DATA_ALU;
        c.regAddr  = RA_PC;
      end
      HALT:    c.halted = 1'b1;
      TRAP:    c.trap   = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  assign ready     = (MEM_HANDSHAKE != 0) ? mem_ready_i : 1'b1;
  assign memState  = (state_q == FETCH_0) || (state_q == LD_0) || (state_q == STR_0);
  assign lowOp     = opcode_i[3:0];
  assign illegalOp = 32'(opcode_i) >= 32'd16;
  assign flagZ     = status_i[0];
  assign flagN     = status_i[1];

  // Two-bit status words carry no overflow flag, so V reads as zero.
  if (STATUS_W >= 4) begin : g_flag_v
    assign flagV = status_i[3];
  end else begin : g_no_flag_v
    assign flagV = 1'b0;
  end

  assign unusedInputs = ^{status_i, mem_ready_i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    timeout = 1'b0;

    // Ready in the same cycle as the last allowed wait beats the timeout.
    if (memState) begin
      if (ready) begin
        cnt_d = '0;
      end else if (MEM_TIMEOUT > 0) begin
        if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else begin
      cnt_d = '0;
    end

    case (state_q)
      FETCH_0: if (ready) state_d = FETCH_1;
      FETCH_1: state_d = DECODE;
      DECODE: begin
        if (illegalOp) begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          case (lowOp)
            4'h0:                               state_d = HALT;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hA: state_d = REG_0;
            4'h6:                               state_d = LD_0;
            4'h7:                               state_d = STR_0;
            4'h8:                               state_d = MOV_0;
            4'h9:                               state_d = MVR_0;
            4'hB:                               state_d = BR_0;
            4'hC: if (flagZ)                    state_d = BR_0; else state_d = FETCH_0;
            4'hD: if (!flagZ)                   state_d = BR_0; else state_d = FETCH_0;
            4'hE: if (flagN ^ flagV)            state_d = BR_0; else state_d = FETCH_0;
            default: begin
              if (!flagZ && !(flagN ^ flagV)) state_d = BR_0;
              else                            state_d = FETCH_0;
            end
          endcase
        end
      end
      REG_0:   if (lowOp == 4'hA) state_d = FETCH_0; else state_d = REG_1;
      REG_1:   state_d = FETCH_0;
      LD_0:    if (ready) state_d = LD_1;
      LD_1:    state_d = FETCH_0;
      STR_0:   if (ready) state_d = FETCH_0;
      MOV_0:   state_d = FETCH_0;
      MVR_0:   state_d = FETCH_0;
      BR_0:    state_d = BR_1;
      BR_1:    state_d = FETCH_0;
      HALT:    if (resume_i) state_d = FETCH_0;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH_0;
    endcase

    if (timeout) begin
      state_d = TRAP;
      cause_d = CAUSE_TIMEOUT;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH_0;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
      ctrl_q  <= decodeCtrl(FETCH_0, 4'h0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      ctrl_q  <= decodeCtrl(state_d, lowOp);
    end
  end

  assign status_we_o     = ctrl_q.statusWe;
  assign alu_op_o        = ctrl_q.aluOp;
  assign alu_in0_o       = ctrl_q.aluIn0;
  assign alu_in1_o       = ctrl_q.aluIn1;
  assign memory_write_o  = ctrl_q.memWrite;
  assign memory_addr_o   = ctrl_q.memAddr;
  assign mem_req_o       = ctrl_q.memReq;
  assign reg_data_o      = ctrl_q.regData;
  assign reg_addr_o      = ctrl_q.regAddr;
  assign regfile_write_o = ctrl_q.regWrite;
  assign halted_o        = ctrl_q.halted;
  assign trap_o          = ctrl_q.trap;
  assign trap_cause_o    = cause_q;
  assign state_o         = state_q;
  assign ins_reg_o       = rst_ni && ready && (state_q == FETCH_0);

endmodule

// File: tb/tb_fsm_control_gen2.sv
// Bench for fsm_control_gen2: per-cycle vector table through a scoreboard
// queue, plus hand-written reset, trap and timeout sequences.
module tb_fsm_control_gen2;

  localparam int OPCODE_W = 5;
  localparam int STATUS_W = 4;

  logic                clk = 1'b0;
  logic                rstN;
  logic [OPCODE_W-1:0] opcode;
  logic [STATUS_W-1:0] status;
  logic                memReady;
  logic                resume;
  logic                statusWe;
  logic [2:0]          aluOp;
  logic                aluIn0;
  logic [1:0]          aluIn1;
  logic                memWrite;
  logic [1:0]          memAddr;
  logic                insReg;
  logic                memReq;
  logic [1:0]          regData;
  logic [1:0]          regAddr;
  logic                regWrite;
  logic                halted;
  logic                trap;
  logic [1:0]          trapCause;
  logic [3:0]          stateOut;

  typedef struct packed {
    logic [3:0] state;
    logic       memReq;
    logic       memWrite;
    logic [1:0] memAddr;
    logic       regWrite;
    logic [1:0] regData;
    logic [1:0] regAddr;
    logic       statusWe;
    logic [2:0] aluOp;
    logic       aluIn0;
    logic [1:0] aluIn1;
    logic       halted;
    logic       trap;
    logic [1:0] cause;
  } expect_t;

  typedef struct {
    logic [OPCODE_W-1:0] opcode;
    logic [STATUS_W-1:0] status;
    logic                memReady;
    logic                resume;
    expect_t             exp;
  } vec_t;

  vec_t    vectors[$];
  expect_t expQ[$];
  int      checks = 0;
  int      passes = 0;
  int      vecNum = 0;

  always #5 clk = ~clk;

  fsm_control_gen2 #(
    .OPCODE_W(OPCODE_W),
    .STATUS_W(STATUS_W),
    .MEM_HANDSHAKE(1),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .opcode_i(opcode),
    .status_i(status),
    .mem_ready_i(memReady),
    .resume_i(resume),
    .status_we_o(statusWe),
    .alu_op_o(aluOp),
    .alu_in0_o(aluIn0),
    .alu_in1_o(aluIn1),
    .memory_write_o(memWrite),
    .memory_addr_o(memAddr),
    .ins_reg_o(insReg),
    .mem_req_o(memReq),
    .reg_data_o(regData),
    .reg_addr_o(regAddr),
    .regfile_write_o(regWrite),
    .halted_o(halted),
    .trap_o(trap),
    .trap_cause_o(trapCause),
    .state_o(stateOut)
  );

  function automatic expect_t mk(input logic [3:0] st, input logic mq, input logic mw,
                                 input logic [1:0] ma, input logic rw, input logic [1:0] rd,
                                 input logic [1:0] ra, input logic sw, input logic [2:0] op,
                                 input logic i0, input logic [1:0] i1, input logic h,
                                 input logic t, input logic [1:0] c);
    expect_t e;
    e.state = st;    e.memReq = mq;   e.memWrite = mw; e.memAddr = ma;
    e.regWrite = rw; e.regData = rd;  e.regAddr = ra;  e.statusWe = sw;
    e.aluOp = op;    e.aluIn0 = i0;   e.aluIn1 = i1;   e.halted = h;
    e.trap = t;      e.cause = c;
    return e;
  endfunction

  function automatic expect_t eF0();
    return mk(4'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd3, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eF1();
    return mk(4'd1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd2, 1'b0, 3'd3, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eDec();
    return mk(4'd2, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd3, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eHalt();
    return mk(4'd3, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd3, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eReg0(input logic [2:0] op);
    return mk(4'd4, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, op, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eReg1(input logic [2:0] op);
    return mk(4'd5, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd0, 1'b0, op, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eLd0();
    return mk(4'd6, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0, 3'd3, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eLd1();
    return mk(4'd7, 1'b0, 1'b0, 2'd2, 1'b1, 2'd1, 2'd1, 1'b0, 3'd3, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eStr();
    return mk(4'd8, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 3'd3, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eMov();
    return mk(4'd9, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 3'd3, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eMvr();
    return mk(4'd10, 1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 2'd1, 1'b0, 3'd3, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eBr0();
    return mk(4'd11, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd3, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eBr1();
    return mk(4'd12, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd2, 1'b0, 3'd3, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0);
  endfunction
  function automatic expect_t eTrap(input logic [1:0] c);
    return mk(4'd13, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd3, 1'b1, 2'd2, 1'b0, 1'b1, c);
  endfunction

  function automatic expect_t sampleDut();
    expect_t a;
    a.state = stateOut;  a.memReq = memReq;   a.memWrite = memWrite; a.memAddr = memAddr;
    a.regWrite = regWrite; a.regData = regData; a.regAddr = regAddr; a.statusWe = statusWe;
    a.aluOp = aluOp;     a.aluIn0 = aluIn0;   a.aluIn1 = aluIn1;     a.halted = halted;
    a.trap = trap;       a.cause = trapCause;
    return a;
  endfunction

  task automatic v(input logic [OPCODE_W-1:0] op, input logic [STATUS_W-1:0] st,
                   input logic rdy, input logic res, input expect_t e);
    vec_t r;
    r.opcode = op; r.status = st; r.memReady = rdy; r.resume = res; r.exp = e;
    vectors.push_back(r);
  endtask

  task automatic regInstr(input logic [OPCODE_W-1:0] op, input logic [2:0] aluSel);
    v(op, 4'h0, 1'b1, 1'b0, eF1());
    v(op, 4'h0, 1'b1, 1'b0, eDec());
    v(op, 4'h0, 1'b1, 1'b0, eReg0(aluSel));
    v(op, 4'h0, 1'b1, 1'b0, eReg1(aluSel));
    v(op, 4'h0, 1'b1, 1'b0, eF0());
  endtask

  task automatic branchTaken(input logic [OPCODE_W-1:0] op, input logic [STATUS_W-1:0] st);
    v(op, st, 1'b1, 1'b0, eF1());
    v(op, st, 1'b1, 1'b0, eDec());
    v(op, st, 1'b1, 1'b0, eBr0());
    v(op, st, 1'b1, 1'b0, eBr1());
    v(op, st, 1'b1, 1'b0, eF0());
  endtask

  task automatic branchSkipped(input logic [OPCODE_W-1:0] op, input logic [STATUS_W-1:0] st);
    v(op, st, 1'b1, 1'b0, eF1());
    v(op, st, 1'b1, 1'b0, eDec());
    v(op, st, 1'b1, 1'b0, eF0());
  endtask

  task automatic checkOutput(input string tag, input expect_t exp);
    expect_t act;
    act = sampleDut();
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h (state got %0d expected %0d)",
                  tag, act, exp, act.state, exp.state);
  endtask

  task automatic checkBit(input string tag, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %b expected %b", tag, act, exp);
  endtask

  task automatic applyStimulus(input vec_t r);
    opcode   = r.opcode;
    status   = r.status;
    memReady = r.memReady;
    resume   = r.resume;
    expQ.push_back(r.exp);
    @(posedge clk);
    #1;
    vecNum++;
    if (expQ.size() == 0) begin
      checks++;
      $display("[TB] FAIL vec%0d: scoreboard empty", vecNum);
    end else begin
      checkOutput($sformatf("vec%0d", vecNum), expQ.pop_front());
    end
  endtask

  task automatic runVectors();
    foreach (vectors[i]) applyStimulus(vectors[i]);
    vectors.delete();
  endtask

  task automatic pulseReset(input string tag);
    rstN = 1'b0;
    #1;
    checkOutput(tag, eF0());
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    rstN     = 1'b1;
    opcode   = '0;
    status   = '0;
    memReady = 1'b1;
    resume   = 1'b0;
    #1 rstN  = 1'b0;
    #6;
    checkOutput("reset_state", eF0());
    checkBit("reset_ins_reg", insReg, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    #1 checkBit("fetch_ins_reg", insReg, 1'b1);
    memReady = 1'b0;
    #1 checkBit("fetch_wait_ins_reg", insReg, 1'b0);

    regInstr(5'h04, 3'd3);
    regInstr(5'h01, 3'd0);
    regInstr(5'h02, 3'd1);
    regInstr(5'h03, 3'd2);
    regInstr(5'h05, 3'd4);
    v(5'h0A, 4'h0, 1'b1, 1'b0, eF1());
    v(5'h0A, 4'h0, 1'b1, 1'b0, eDec());
    v(5'h0A, 4'h0, 1'b1, 1'b0, eReg0(3'd4));
    v(5'h0A, 4'h0, 1'b1, 1'b0, eF0());
    v(5'h06, 4'h0, 1'b1, 1'b0, eF1());
    v(5'h06, 4'h0, 1'b1, 1'b0, eDec());
    v(5'h06, 4'h0, 1'b1, 1'b0, eLd0());
    for (int i = 0; i < 3; i++) v(5'h06, 4'h0, 1'b0, 1'b0, eLd0());
    v(5'h06, 4'h0, 1'b1, 1'b0, eLd1());
    v(5'h06, 4'h0, 1'b1, 1'b0, eF0());
    v(5'h07, 4'h0, 1'b1, 1'b0, eF1());
    v(5'h07, 4'h0, 1'b1, 1'b0, eDec());
    v(5'h07, 4'h0, 1'b1, 1'b0, eStr());
    v(5'h07, 4'h0, 1'b1, 1'b0, eF0());
    v(5'h08, 4'h0, 1'b1, 1'b0, eF1());
    v(5'h08, 4'h0, 1'b0, 1'b0, eDec());
    v(5'h08, 4'h0, 1'b0, 1'b0, eMov());
    v(5'h08, 4'h0, 1'b0, 1'b0, eF0());
    v(5'h09, 4'h0, 1'b1, 1'b0, eF1());
    v(5'h09, 4'h0, 1'b1, 1'b0, eDec());
    v(5'h09, 4'h0, 1'b1, 1'b0, eMvr());
    v(5'h09, 4'h0, 1'b1, 1'b0, eF0());
    branchTaken(5'h0B, 4'h0);
    branchTaken(5'h0C, 4'h1);
    branchSkipped(5'h0C, 4'h4);
    branchSkipped(5'h0D, 4'h1);
    branchTaken(5'h0D, 4'h0);
    branchTaken(5'h0E, 4'h8);
    branchSkipped(5'h0E, 4'hA);
    branchTaken(5'h0F, 4'h4);
    branchSkipped(5'h0F, 4'h1);
    branchSkipped(5'h0F, 4'h8);
    v(5'h00, 4'h0, 1'b0, 1'b0, eF0());
    v(5'h00, 4'h0, 1'b1, 1'b0, eF1());
    v(5'h00, 4'h0, 1'b1, 1'b1, eDec());
    v(5'h00, 4'h0, 1'b1, 1'b0, eHalt());
    v(5'h00, 4'h0, 1'b1, 1'b0, eHalt());
    v(5'h00, 4'h0, 1'b1, 1'b1, eF0());
    runVectors();

    // Ready on the last allowed wait cycle, then a real timeout in STR_0.
    v(5'h07, 4'h0, 1'b1, 1'b0, eF1());
    v(5'h07, 4'h0, 1'b1, 1'b0, eDec());
    v(5'h07, 4'h0, 1'b1, 1'b0, eStr());
    for (int i = 0; i < 3; i++) v(5'h07, 4'h0, 1'b0, 1'b0, eStr());
    v(5'h07, 4'h0, 1'b1, 1'b0, eF0());
    v(5'h07, 4'h0, 1'b1, 1'b0, eF1());
    v(5'h07, 4'h0, 1'b1, 1'b0, eDec());
    v(5'h07, 4'h0, 1'b1, 1'b0, eStr());
    for (int i = 0; i < 3; i++) v(5'h07, 4'h0, 1'b0, 1'b0, eStr());
    v(5'h07, 4'h0, 1'b0, 1'b0, eTrap(2'b10));
    v(5'h07, 4'h0, 1'b1, 1'b0, eTrap(2'b10));
    v(5'h00, 4'h0, 1'b1, 1'b1, eTrap(2'b10));
    runVectors();
    pulseReset("timeout_trap_reset");

    v(5'h13, 4'h0, 1'b1, 1'b0, eF1());
    v(5'h13, 4'h0, 1'b1, 1'b0, eDec());
    v(5'h13, 4'h0, 1'b1, 1'b0, eTrap(2'b01));
    v(5'h13, 4'h0, 1'b1, 1'b1, eTrap(2'b01));
    runVectors();
    pulseReset("illegal_trap_reset");

    v(5'h0B, 4'h0, 1'b1, 1'b0, eF1());
    v(5'h0B, 4'h0, 1'b1, 1'b0, eDec());
    v(5'h0B, 4'h0, 1'b1, 1'b0, eBr0());
    runVectors();
    #2 rstN = 1'b0;
    #1 checkOutput("async_reset_br0", eF0());
    @(negedge clk);
    rstN = 1'b1;
    v(5'h04, 4'h0, 1'b1, 1'b0, eF1());
    runVectors();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
